// File: rtl/ca_row_stepper_if.sv
// Handshake and data bundle for ca_row_stepper.
// The load side carries a row and a generation count in. The result side
// returns the evolved row. The busy flag shows that a computation is running.
interface ca_row_stepper_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_row;
  logic [7:0]       load_gens;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_row;
  logic             busy;

  // Requester / consumer side.
  modport master (
    output load_valid, load_row, load_gens, out_ready,
    input  load_ready, out_valid, out_row, busy
  );

  // Stepper side.
  modport slave (
    input  load_valid, load_row, load_gens, out_ready,
    output load_ready, out_valid, out_row, busy
  );
endinterface

// File: rtl/ca_row_stepper.sv
// ca_row_stepper: a 1-D cellular automaton. It steps a WIDTH-cell row for a
// requested number of generations and evaluates one cell per clock.
// Rule: new = left XOR (right AND centre), where left = row[i-1] and
// right = row[i+1].
// Optional macro CA_WRAP_EN: periodic boundaries. Without it, the neighbours
// outside the row read as 0.
//
//   state | meaning
//   IDLE  | waiting for a load; load_ready high
//   RUN   | evaluating cells; busy high
//   DONE  | result held on out_row; out_valid high until out_ready
module ca_row_stepper #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               reset,
  ca_row_stepper_if.slave   bus
);

  localparam int IDXW = $clog2(WIDTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

`ifdef CA_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_row;
  logic [WIDTH-1:0] r_shadow;
  logic [7:0]       r_gens;
  logic [IDXW-1:0]  r_idx;

  logic w_in1;
  logic w_in2;
  logic w_in3;
  logic w_new_cell;
  logic w_load_ready;
  logic w_busy;
  logic w_out_valid;

  // Gather the neighbourhood of cell r_idx from the previous generation.
  always_comb begin
    w_in2 = r_row[r_idx];
    if (r_idx == LAST_IDX) w_in1 = WRAP ? r_row[0] : 1'b0;
    else                   w_in1 = r_row[r_idx + 1'b1];
    if (r_idx == '0)       w_in3 = WRAP ? r_row[WIDTH-1] : 1'b0;
    else                   w_in3 = r_row[r_idx - 1'b1];
    w_new_cell = w_in3 ^ (w_in1 & w_in2);
  end

  // Compute the next state and decode the outputs from the current state.
  always_comb begin
    w_next_state = r_state;
    w_load_ready = 1'b0;
    w_busy       = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load_ready = 1'b1;
        if (bus.load_valid)
          w_next_state = (bus.load_gens == 8'd0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (r_idx == LAST_IDX && r_gens == 8'd1)
          w_next_state = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready)
          w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Register the state. Capture loads, build each generation in the shadow
  // and commit it to the row register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_row    <= '0;
      r_shadow <= '0;
      r_gens   <= '0;
      r_idx    <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (bus.load_valid) begin
            r_row  <= bus.load_row;
            r_gens <= bus.load_gens;
            r_idx  <= '0;
          end
        end
        S_RUN: begin
          r_shadow[r_idx] <= w_new_cell;
          if (r_idx == LAST_IDX) begin
            // The last cell goes straight into the committed row. The shadow
            // write for that cell lands on the same edge.
            r_row  <= {w_new_cell, r_shadow[WIDTH-2:0]};
            r_gens <= r_gens - 8'd1;
            r_idx  <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.load_ready = w_load_ready;
  assign bus.busy       = w_busy;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_row    = r_row;

endmodule
